// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Request scheduler in front of the byte-serial memory controller. Shares the
// single RAM port between instruction fetch, LSB loads and ROB-committed
// stores. Committed stores are queued in a small FIFO and drain ahead of all
// other traffic; loads are held off while any store is pending. A mispredict
// flush blocks new fetch/load grants and discards the result of an in-flight
// fetch/load without disturbing the controller handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rdy                 global enable; all state holds while low
//   flush               mispredict flush
//   if_req/if_addr      fetch request (level) -> if_done/if_data
//   ld_req/ld_addr/ld_size/ld_sign
//                       load request (level) -> ld_done/ld_data
//   st_req/st_addr/st_data/st_size
//                       store push (pulse) -> st_ack, st_full
//   mc_valid/mc_kind/mc_addr/mc_size/mc_sign/mc_wdata
//                       transaction to the controller (kind 0 fetch, 1 load, 2 store)
//   mc_done/mc_rdata    controller completion and read data
//   idle                FSM idle and store FIFO empty
//
// Build option:
//   MEM_ARB_STARVE_EN   when defined, a fetch that has waited through
//                       STARVE_LIMIT consecutive store/load grants is granted
//                       ahead of everything else.

module mem_arbiter #(
    parameter int ST_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    input  logic        ld_sign,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_size,
    output logic        st_ack,
    output logic        st_full,
    output logic        mc_valid,
    output logic [1:0]  mc_kind,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_size,
    output logic        mc_sign,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata,
    output logic        idle
);

    localparam int PW = $clog2(ST_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    if ((ST_DEPTH < 2) || ((ST_DEPTH & (ST_DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_param_check
        $error("mem_arbiter: ST_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state, state_nxt;

    // store FIFO
    logic [31:0]   fifo_addr [ST_DEPTH];
    logic [31:0]   fifo_data [ST_DEPTH];
    logic [2:0]    fifo_size [ST_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;

    logic push, pop;
    logic gnt_fetch, gnt_load, gnt_store;
    logic starve_force;

    // set when a flush hits an in-flight fetch/load; its completion is dropped
    logic discard, discard_nxt;

    logic        mc_valid_nxt;
    logic [1:0]  mc_kind_nxt;
    logic [31:0] mc_addr_nxt;
    logic [2:0]  mc_size_nxt;
    logic        mc_sign_nxt;
    logic [31:0] mc_wdata_nxt;
    logic        if_done_nxt, ld_done_nxt;
    logic [31:0] if_data_nxt, ld_data_nxt;

    // st_full is the registered pre-edge view, so a push in the same cycle as a
    // pop from a full FIFO is rejected
    assign push = st_req && !st_full;

    always_comb begin
        state_nxt    = state;
        discard_nxt  = discard;
        mc_valid_nxt = mc_valid;
        mc_kind_nxt  = mc_kind;
        mc_addr_nxt  = mc_addr;
        mc_size_nxt  = mc_size;
        mc_sign_nxt  = mc_sign;
        mc_wdata_nxt = mc_wdata;
        if_done_nxt  = 1'b0;
        if_data_nxt  = if_data;
        ld_done_nxt  = 1'b0;
        ld_data_nxt  = ld_data;
        pop          = 1'b0;
        gnt_fetch    = 1'b0;
        gnt_load     = 1'b0;
        gnt_store    = 1'b0;

        case (state)
            S_IDLE: begin
                if (starve_force && if_req && !flush)
                    gnt_fetch = 1'b1;
                else if (count != '0)
                    gnt_store = 1'b1;
                else if (ld_req && !flush)
                    gnt_load = 1'b1;
                else if (if_req && !flush)
                    gnt_fetch = 1'b1;

                if (gnt_store) begin
                    mc_kind_nxt  = K_STORE;
                    mc_addr_nxt  = fifo_addr[rd_ptr];
                    mc_size_nxt  = fifo_size[rd_ptr];
                    mc_sign_nxt  = 1'b0;
                    mc_wdata_nxt = fifo_data[rd_ptr];
                end else if (gnt_load) begin
                    mc_kind_nxt  = K_LOAD;
                    mc_addr_nxt  = ld_addr;
                    mc_size_nxt  = ld_size;
                    mc_sign_nxt  = ld_sign;
                    mc_wdata_nxt = '0;
                end else if (gnt_fetch) begin
                    mc_kind_nxt  = K_FETCH;
                    mc_addr_nxt  = if_addr;
                    mc_size_nxt  = 3'd4;
                    mc_sign_nxt  = 1'b0;
                    mc_wdata_nxt = '0;
                end

                if (gnt_store || gnt_load || gnt_fetch) begin
                    state_nxt    = S_BUSY;
                    mc_valid_nxt = 1'b1;
                    discard_nxt  = 1'b0;
                end
            end

            S_BUSY: begin
                if (flush && (mc_kind != K_STORE))
                    discard_nxt = 1'b1;

                if (mc_done) begin
                    state_nxt    = S_IDLE;
                    mc_valid_nxt = 1'b0;
                    discard_nxt  = 1'b0;
                    case (mc_kind)
                        K_FETCH: begin
                            if (!discard && !flush) begin
                                if_done_nxt = 1'b1;
                                if_data_nxt = mc_rdata;
                            end
                        end
                        K_LOAD: begin
                            if (!discard && !flush) begin
                                ld_done_nxt = 1'b1;
                                ld_data_nxt = mc_rdata;
                            end
                        end
                        K_STORE: pop = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mc_valid <= 1'b0;
            mc_kind  <= '0;
            mc_addr  <= '0;
            mc_size  <= '0;
            mc_sign  <= 1'b0;
            mc_wdata <= '0;
            if_done  <= 1'b0;
            if_data  <= '0;
            ld_done  <= 1'b0;
            ld_data  <= '0;
            st_ack   <= 1'b0;
            st_full  <= 1'b0;
            idle     <= 1'b0;
        end else if (rdy) begin
            discard  <= discard_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nxt;
            mc_valid <= mc_valid_nxt;
            mc_kind  <= mc_kind_nxt;
            mc_addr  <= mc_addr_nxt;
            mc_size  <= mc_size_nxt;
            mc_sign  <= mc_sign_nxt;
            mc_wdata <= mc_wdata_nxt;
            if_done  <= if_done_nxt;
            if_data  <= if_data_nxt;
            ld_done  <= ld_done_nxt;
            ld_data  <= ld_data_nxt;
            st_ack   <= push;
            st_full  <= (count_nxt == CW'(ST_DEPTH));
            idle     <= (state_nxt == S_IDLE) && (count_nxt == '0);
        end
    end

    // FIFO storage needs no reset; only the pointers and count define contents
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            fifo_addr[wr_ptr] <= st_addr;
            fifo_data[wr_ptr] <= st_data;
            fifo_size[wr_ptr] <= st_size;
        end
    end

`ifdef MEM_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    assign starve_force = (starve_cnt == SW'(STARVE_LIMIT));

    // saturates at the limit so a flush-blocked fetch keeps its priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (rdy) begin
            if (!if_req || gnt_fetch)
                starve_cnt <= '0;
            else if ((gnt_store || gnt_load) && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign starve_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic        ld_sign;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_size;
    logic        st_ack;
    logic        st_full;
    logic        mc_valid;
    logic [1:0]  mc_kind;
    logic [31:0] mc_addr;
    logic [2:0]  mc_size;
    logic        mc_sign;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ST_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_sign(ld_sign),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ack(st_ack), .st_full(st_full),
        .mc_valid(mc_valid), .mc_kind(mc_kind), .mc_addr(mc_addr), .mc_size(mc_size),
        .mc_sign(mc_sign), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;        // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [2:0]  size;
        logic        sign;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  exp_kind;
        logic [2:0]  exp_size;
        logic        exp_sign;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!mc_valid && i < 50) begin
            tick();
            i++;
        end
        if (!mc_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: mc_valid never rose (got 0 expected 1)", name);
        end
    endtask

    task automatic complete(input logic [31:0] rdata);
        mc_done  = 1'b1;
        mc_rdata = rdata;
        tick();
        mc_done  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int n_st;
        bit seen;
        int exp_st;

        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ld_req = 1'b0; ld_addr = '0; ld_size = '0; ld_sign = 1'b0;
        st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        mc_done = 1'b0; mc_rdata = '0;

        //           op addr          sz    sg    wdata         rdata         kind  esz   esg   exp_data
        vecs[0] = '{0, 32'h0000_0200, 3'd1, 1'b0, 32'h0,        32'h1122_3344, 2'd0, 3'd4, 1'b0, 32'h1122_3344};
        vecs[1] = '{1, 32'h0000_1000, 3'd1, 1'b1, 32'h0,        32'hFFFF_FF80, 2'd1, 3'd1, 1'b1, 32'hFFFF_FF80};
        vecs[2] = '{1, 32'h0003_0004, 3'd2, 1'b0, 32'h0,        32'h0000_BEEF, 2'd1, 3'd2, 1'b0, 32'h0000_BEEF};
        vecs[3] = '{2, 32'h0000_0040, 3'd4, 1'b0, 32'hCAFE_F00D, 32'h0,       2'd2, 3'd4, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{2, 32'h0000_0041, 3'd1, 1'b0, 32'h0000_00AB, 32'h0,       2'd2, 3'd1, 1'b0, 32'h0000_00AB};
        vecs[5] = '{1, 32'h0000_2000, 3'd4, 1'b0, 32'h0,        32'h1234_5678, 2'd1, 3'd4, 1'b0, 32'h1234_5678};

        // reset state, then a fetch presented through reset
        repeat (2) @(posedge clk);
        #1;
        check("rst mc_valid", mc_valid, 0);
        check("rst mc_addr", mc_addr, 0);
        check("rst if_done", if_done, 0);
        check("rst st_full", st_full, 0);
        check("rst st_ack", st_ack, 0);
        check("rst idle", idle, 0);
        if_req = 1'b1; if_addr = 32'h100;
        rst = 1'b1;
        tick();
        check("f1 mc_valid", mc_valid, 1);
        check("f1 mc_kind", mc_kind, 0);
        check("f1 mc_addr", mc_addr, 32'h100);
        check("f1 mc_size", mc_size, 4);
        tick();
        check("f1 hold mc_valid", mc_valid, 1);
        if_addr = 32'h104;
        complete(32'hDEAD_BEEF);
        check("f1 if_done", if_done, 1);
        check("f1 if_data", if_data, 32'hDEAD_BEEF);
        check("f1 bubble mc_valid", mc_valid, 0);
        tick();
        check("f2 mc_valid k+2", mc_valid, 1);
        check("f2 mc_addr", mc_addr, 32'h104);
        check("f1 if_done one cycle", if_done, 0);
        // rdy low freezes everything, including a sampled mc_done
        rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h0BAD_F00D;
        tick();
        check("rdy0 mc_valid hold", mc_valid, 1);
        check("rdy0 no done", if_done, 0);
        rdy = 1'b1;
        tick();
        mc_done = 1'b0; if_req = 1'b0; rdy = 1'b0;
        check("f2 if_done", if_done, 1);
        check("f2 if_data", if_data, 32'h0BAD_F00D);
        repeat (2) tick();
        check("rdy0 pulse held", if_done, 1);
        rdy = 1'b1;
        tick();
        check("rdy1 pulse cleared", if_done, 0);
        check("f2 idle", idle, 1);

        // table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            case (v.op)
                0: begin if_req = 1'b1; if_addr = v.addr; end
                1: begin ld_req = 1'b1; ld_addr = v.addr; ld_size = v.size; ld_sign = v.sign; end
                default: begin
                    st_req = 1'b1; st_addr = v.addr; st_data = v.wdata; st_size = v.size;
                    tick();
                    st_req = 1'b0;
                    check($sformatf("vec%0d st_ack", i), st_ack, 1);
                end
            endcase
            wait_valid($sformatf("vec%0d grant", i));
            check($sformatf("vec%0d mc_kind", i), mc_kind, v.exp_kind);
            check($sformatf("vec%0d mc_addr", i), mc_addr, v.addr);
            check($sformatf("vec%0d mc_size", i), mc_size, v.exp_size);
            if (v.op == 1) check($sformatf("vec%0d mc_sign", i), mc_sign, v.exp_sign);
            if (v.op == 2) check($sformatf("vec%0d mc_wdata", i), mc_wdata, v.exp_data);
            complete(v.rdata);
            if_req = 1'b0; ld_req = 1'b0;
            check($sformatf("vec%0d mc_valid drop", i), mc_valid, 0);
            check($sformatf("vec%0d if_done", i), if_done, (v.op == 0) ? 1 : 0);
            check($sformatf("vec%0d ld_done", i), ld_done, (v.op == 1) ? 1 : 0);
            if (v.op == 0) check($sformatf("vec%0d if_data", i), if_data, v.exp_data);
            if (v.op == 1) check($sformatf("vec%0d ld_data", i), ld_data, v.exp_data);
            tick();
            check($sformatf("vec%0d idle", i), idle, 1);
        end

        // fill the FIFO, reject pushes while full (including push + pop same cycle)
        for (int i = 0; i < 4; i++) begin
            st_req = 1'b1; st_addr = 32'h100 + 32'(i * 4); st_data = 32'hA000_0000 + 32'(i);
            st_size = (i == 1) ? 3'd2 : (i == 2) ? 3'd1 : 3'd4;
            tick();
            check($sformatf("fill%0d st_ack", i), st_ack, 1);
        end
        check("fill st_full", st_full, 1);
        st_addr = 32'h1F0; st_data = 32'hFFFF_FFFF;
        tick();
        check("full push no ack", st_ack, 0);
        check("full st_full hold", st_full, 1);
        check("fill s0 mc_addr", mc_addr, 32'h100);
        check("fill s0 mc_wdata", mc_wdata, 32'hA000_0000);
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0; st_req = 1'b0;
        check("push+pop full no ack", st_ack, 0);
        check("pop clears st_full", st_full, 0);
        for (int i = 1; i < 4; i++) begin
            wait_valid($sformatf("drain%0d grant", i));
            check($sformatf("drain%0d mc_addr", i), mc_addr, 32'h100 + 32'(i * 4));
            check($sformatf("drain%0d mc_wdata", i), mc_wdata, 32'hA000_0000 + 32'(i));
            check($sformatf("drain%0d mc_size", i), mc_size, (i == 1) ? 2 : (i == 2) ? 1 : 4);
            complete(32'h0);
        end
        tick();
        check("drain idle", idle, 1);

        // load waits behind two queued stores
        st_req = 1'b1; st_addr = 32'h500; st_data = 32'h5; st_size = 3'd4;
        tick();
        st_addr = 32'h504; st_data = 32'h6;
        tick();
        st_req = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h3_0000; ld_size = 3'd4; ld_sign = 1'b0;
        wait_valid("ord s0 grant");
        check("ord s0 kind", mc_kind, 2);
        check("ord s0 addr", mc_addr, 32'h500);
        complete(32'h0);
        wait_valid("ord s1 grant");
        check("ord s1 kind", mc_kind, 2);
        check("ord s1 addr", mc_addr, 32'h504);
        complete(32'h0);
        check("ord no early ld_done", ld_done, 0);
        wait_valid("ord ld grant");
        check("ord ld kind", mc_kind, 1);
        check("ord ld addr", mc_addr, 32'h3_0000);
        complete(32'h0000_0055);
        ld_req = 1'b0;
        check("ord ld_done", ld_done, 1);
        check("ord ld_data", ld_data, 32'h55);
        tick();

        // flush blocks a grant in IDLE, then discards an in-flight fetch
        if_req = 1'b1; if_addr = 32'h300; flush = 1'b1;
        tick();
        check("flush idle no grant", mc_valid, 0);
        flush = 1'b0;
        tick();
        check("fl fetch grant", mc_valid, 1);
        check("fl fetch addr", mc_addr, 32'h300);
        st_req = 1'b1; st_addr = 32'h600; st_data = 32'h66; st_size = 3'd4;
        tick();
        st_req = 1'b0;
        check("fl st_ack", st_ack, 1);
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        check("fl busy holds", mc_valid, 1);
        complete(32'h77);
        check("fl if_done suppressed", if_done, 0);
        check("fl mc_valid drop", mc_valid, 0);
        wait_valid("fl store grant");
        check("fl store kind", mc_kind, 2);
        check("fl store addr", mc_addr, 32'h600);
        check("fl store wdata", mc_wdata, 32'h66);
        flush = 1'b1;
        complete(32'h0);
        flush = 1'b0;
        check("fl store popped idle", idle, 1);

        // flush coinciding with mc_done on a load
        ld_req = 1'b1; ld_addr = 32'h1234; ld_size = 3'd4;
        tick();
        check("fl ld grant kind", mc_kind, 1);
        flush = 1'b1;
        complete(32'h99);
        flush = 1'b0; ld_req = 1'b0;
        check("fl ld_done suppressed", ld_done, 0);
        tick();
        check("fl ld idle", idle, 1);

        // discard does not leak into the next transaction
        if_req = 1'b1; if_addr = 32'h400;
        wait_valid("post-flush fetch grant");
        complete(32'h4040_4040);
        if_req = 1'b0;
        check("post-flush if_done", if_done, 1);
        check("post-flush if_data", if_data, 32'h4040_4040);
        tick();

        // starvation: stores keep arriving while a fetch waits
        for (int i = 0; i < 4; i++) begin
            st_req = 1'b1; st_addr = 32'h800 + 32'(i * 4); st_data = 32'(i); st_size = 3'd4;
            tick();
        end
        st_req = 1'b0;
        complete(32'h0);
        if_req = 1'b1; if_addr = 32'h900;
        pushed = 4; n_st = 0; seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (mc_valid && mc_kind == 2'd0) begin
                seen = 1'b1;
            end else begin
                if (mc_valid && mc_kind == 2'd2) n_st++;
                mc_done = mc_valid;
                st_req  = (pushed < 12) && !st_full;
                st_addr = 32'h800 + 32'(pushed * 4);
                st_data = 32'(pushed);
                tick();
                if (st_req) pushed++;
            end
        end
        st_req = 1'b0; mc_done = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        exp_st = 8;
`else
        exp_st = 11;
`endif
        check("starve fetch granted", 32'(seen), 1);
        check("starve store grants", n_st, exp_st);
        check("starve fetch addr", mc_addr, 32'h900);
        complete(32'h9999_0000);
        if_req = 1'b0;
        check("starve if_done", if_done, 1);
        check("starve if_data", if_data, 32'h9999_0000);
        for (int c = 0; c < 100 && !idle; c++) begin
            mc_done = mc_valid;
            tick();
        end
        mc_done = 1'b0;
        check("starve drain idle", idle, 1);

        // asynchronous reset in the middle of a transaction
        if_req = 1'b1; if_addr = 32'hA00;
        wait_valid("rst-mid grant");
        #3;
        rst = 1'b0;
        #1;
        check("async rst mc_valid", mc_valid, 0);
        check("async rst mc_addr", mc_addr, 0);
        check("async rst mc_size", mc_size, 0);
        check("async rst idle", idle, 0);
        if_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post-rst idle", idle, 1);
        check("post-rst mc_valid", mc_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Request scheduler in front of the byte-serial memory controller. It shares the single RAM port between three requesters: instruction fetch, LSB loads, and ROB-committed stores. Committed stores go into a small FIFO and drain ahead of everything else. Loads may not bypass pending stores. A branch-mispredict flush kills speculative fetch/load traffic without corrupting an in-flight controller transaction.

## Interface
Parameters:
- ST_DEPTH, 4: store FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive non-fetch grants tolerated while a fetch waits (used only with MEM_ARB_STARVE_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  mispredict (xbp) flush.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched word.
- ld_req  in  1  load request; level, held until ld_done.
- ld_addr  in  32  load address.
- ld_size  in  3  1/2/4 bytes.
- ld_sign  in  1  sign-extend.
- ld_done  out  1  one-cycle pulse: ld_data valid.
- ld_data  out  32  extended load data.
- st_req  in  1  store push; single-cycle pulse.
- st_addr  in  32  store address.
- st_data  in  32  store data.
- st_size  in  3  1/2/4 bytes.
- st_ack  out  1  pulse the cycle after a push is accepted.
- st_full  out  1  FIFO count == ST_DEPTH.
- mc_valid  out  1  transaction presented to the controller.
- mc_kind  out  2  0 fetch, 1 load, 2 store.
- mc_addr  out  32  transaction address.
- mc_size  out  3  byte count (fetch is always 4).
- mc_sign  out  1  load sign flag.
- mc_wdata  out  32  store data.
- mc_done  in  1  controller finished; mc_rdata valid.
- mc_rdata  in  32  read result.
- idle  out  1  FSM in IDLE and FIFO empty.

## Operation
- FSM states: IDLE and BUSY.
- IDLE → BUSY on a grant. Grant priority:
  1. FIFO non-empty: head store.
  2. ld_req, only when FIFO is empty. This is the load/store ordering rule, and it also covers the IO port (addr[17:16]==2'b11).
  3. if_req.
- On grant, the mc_* outputs are registered from the chosen source and mc_valid is set. Both are held stable through BUSY.
- BUSY → IDLE when mc_done is sampled high. mc_valid drops the same edge.
  - Fetch: if_done is pulsed and if_data = mc_rdata.
  - Load: ld_done is pulsed and ld_data = mc_rdata (the controller sign-extends).
  - Store: FIFO head is popped.
- Store push:
  - Accepted when st_req && !st_full; st_ack pulses the next cycle.
  - When full, the push is ignored (no ack) and the requester retries.
  - Push and pop in the same cycle when full: the push is rejected (st_full is evaluated on the pre-edge count).
- FIFO pointers are log2(ST_DEPTH) bits and wrap modulo ST_DEPTH. Count is log2(ST_DEPTH)+1 bits.
- Flush:
  - No fetch or load is granted in a flush cycle; a store may still be granted.
  - If BUSY with fetch/load, the discard flag is set. The transaction still completes at the controller, but its done pulse and data are suppressed.
  - A flush cycle that coincides with mc_done also suppresses the pulse.
  - Store transactions and FIFO contents are never affected by flush.
- rdy low: no state, pointer or output changes. Pulses already high stay high until rdy returns.
- Reset (rst low, asynchronous): state IDLE, FIFO empty, discard flag cleared, starvation counter 0, every output 0.
- Reset mid-transaction abandons it. The controller is reset by the same signal.

## Timing
- Grant decided at edge t (IDLE, request visible); mc_valid high from t.
- mc_done high in cycle k gives if_done/ld_done/pop at edge k, i.e. visible in cycle k+1. The FSM is IDLE in k+1.
- Earliest next mc_valid is cycle k+2. There is one idle bubble per transaction.
- st_ack latency is 1 cycle. st_full and idle are registered.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A counter increments on each store/load grant while if_req is high.
  - The counter clears on a fetch grant or when if_req is low.
  - When the counter equals STARVE_LIMIT, fetch takes top priority for the next grant.
- Undefined: the counter is absent and fixed priority (store > load > fetch) applies.

## Test plan
- Reset with if_req=1, if_addr=0x100 → mc_valid/kind=0/addr=0x100; mc_done with rdata=0xDEADBEEF → if_done one cycle, if_data=0xDEADBEEF; next grant no earlier than 2 cycles after mc_done.
- Push 4 stores (ST_DEPTH=4) → st_ack each, then st_full=1; a fifth push gives no ack; stores issue in FIFO order with matching addr/data/size.
- ld_req to 0x30000 while 2 stores are queued → both stores issue first, then load kind=1; ld_done follows its mc_done.
- Flush while BUSY on a fetch → no if_done at mc_done; a queued store still issues afterwards; the FIFO count is unchanged by the flush.
- With MEM_ARB_STARVE_EN and STARVE_LIMIT=8, stores pushed continuously plus if_req held → fetch granted after exactly 8 store grants; without the macro, the fetch waits until the FIFO empties.
- rst asserted low mid-BUSY → outputs 0 immediately (asynchronous); idle=1 after release.
